// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings for the 3-bit op field (MULT .. MTLO, 6-7 reserved)
//   - default busy latencies for multiply and divide
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    localparam int MDU_CNT_W = 4;

    // Two's-complement magnitude; 0x80000000 maps to itself, which reads
    // correctly as an unsigned 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu.sv
// mdu: EX-stage multiply/divide unit holding architectural HI/LO.
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   start  - issue strobe, sampled at the rising edge
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 ignored
//   A, B   - rs / rt operands
//   busy   - multiply/divide in flight; following MDU ops must stall
//   HI, LO - architectural HI/LO registers
// The result is computed in one shot at issue and parked in pending
// registers; a down-counter models the multi-cycle latency before commit.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [MDU_CNT_W-1:0] cnt;
    logic [31:0]          pend_hi;
    logic [31:0]          pend_lo;

    logic signed [63:0] a_sx, b_sx;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        a_mag, b_mag, sdiv_q, sdiv_r, udiv_q, udiv_r;
    logic [31:0]        res_hi, res_lo;
    logic               div_zero;
    logic               is_arith;
    logic [MDU_CNT_W-1:0] load_cnt;

    assign div_zero = (B == 32'd0);
    assign is_arith = (op == MDU_MULT) || (op == MDU_MULTU) ||
                      (op == MDU_DIV)  || (op == MDU_DIVU);

    always_comb begin
        a_sx   = $signed({{32{A[31]}}, A});
        b_sx   = $signed({{32{B[31]}}, B});
        prod_s = 64'(a_sx * b_sx);
        prod_u = {32'd0, A} * {32'd0, B};

        // Signed divide through magnitudes: avoids the INT_MIN / -1 overflow
        // trap of a native signed divide and yields 0x80000000 rem 0 there.
        a_mag  = mag32(A);
        b_mag  = div_zero ? 32'd1 : mag32(B);
        sdiv_q = a_mag / b_mag;
        sdiv_r = a_mag % b_mag;
        if (A[31] ^ B[31]) sdiv_q = ~sdiv_q + 32'd1;
        if (A[31])         sdiv_r = ~sdiv_r + 32'd1;

        udiv_q = A / (div_zero ? 32'd1 : B);
        udiv_r = A % (div_zero ? 32'd1 : B);
    end

    always_comb begin
        res_hi   = HI;
        res_lo   = LO;
        load_cnt = MDU_CNT_W'(MULT_CYCLES);
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                load_cnt = MDU_CNT_W'(DIV_CYCLES);
                // divide by zero keeps the current HI/LO as the "result"
                if (!div_zero) begin
                    res_hi = sdiv_r;
                    res_lo = sdiv_q;
                end
            end
            MDU_DIVU: begin
                load_cnt = MDU_CNT_W'(DIV_CYCLES);
                if (!div_zero) begin
                    res_hi = udiv_r;
                    res_lo = udiv_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            HI      <= '0;
            LO      <= '0;
        end else if (busy) begin
            // any start while busy is dropped here, MTxx included
            if (cnt == MDU_CNT_W'(1)) begin
                HI   <= pend_hi;
                LO   <= pend_lo;
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt - MDU_CNT_W'(1);
            end
        end else if (start) begin
            if (is_arith) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= load_cnt;
                busy    <= 1'b1;
            end else if (op == MDU_MTHI) begin
                HI <= A;
            end else if (op == MDU_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule
